// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit history counter states, BTB entry layout
// and the saturating counter update used when training the BHT.
package bp_pkg;

   // Entry fields are sized for the widest supported PC; narrower configurations keep the
   // unused high bits at zero and synthesis trims them.
   localparam int BP_FIELD_W = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_t;

   typedef struct packed {
      logic                  valid;
      logic                  uncond;
      logic [BP_FIELD_W-1:0] tag;
      logic [BP_FIELD_W-1:0] target;
   } btb_entry_t;

   function automatic bht_state_t sat_update(input bht_state_t s, input logic taken);
      bht_state_t r;
      r = s;
      if (taken) begin
         if (s != ST) r = bht_state_t'(s + 2'd1);
      end else begin
         if (s != SNT) r = bht_state_t'(s - 2'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port for fetch lookup,
// one synchronous write port for EX-stage training, synchronous clear of every entry.
module bp_btb
   import bp_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx_i,
   output btb_entry_t       rd_entry_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  btb_entry_t       wr_entry_i
);

   btb_entry_t mem_q [DEPTH];

   // No write-to-read bypass: a lookup in the training cycle sees the old entry.
   assign rd_entry_o = mem_q[rd_idx_i];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_entry_i;
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction (BTB + 2-bit BHT lookup at fetch) and resolution (mispredict
// detection, redirect, table training, saturating mispredict statistics at EX).
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int PC_W  = 9,
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  if_pc,
   output logic             pred_taken,
   output logic [PC_W-1:0]  pred_target,
   input  logic             ex_valid,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic [31:0]      ex_imm,
   input  logic             ex_branch,
   input  logic             ex_jal,
   input  logic             ex_jalr,
   input  logic [31:0]      ex_alu_result,
   input  logic             ex_pred_taken,
   input  logic [PC_W-1:0]  ex_pred_target,
   output logic [31:0]      pc_four,
   output logic [31:0]      pc_imm,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int TAG_SH = IDX_W + 2;

   bht_state_t       bht_q [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [31:0]      if_tag, ex_tag;
   btb_entry_t       rd_entry, wr_entry;
   logic             btb_wr_en;
   logic             hit;

   logic             act_taken;
   logic [31:0]      act_target;
   logic             tgt_oob;
   logic             ex_ctl;

   // Tag is everything above the index; shifting a zero-extended PC gives a zero tag
   // when the index consumes all PC bits, so such entries always match.
   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign if_tag = 32'(if_pc) >> TAG_SH;
   assign ex_tag = 32'(ex_pc) >> TAG_SH;

   bp_btb #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_btb (
      .clk        (clk),
      .reset      (reset),
      .rd_idx_i   (if_idx),
      .rd_entry_o (rd_entry),
      .wr_en_i    (btb_wr_en),
      .wr_idx_i   (ex_idx),
      .wr_entry_i (wr_entry)
   );

   // Stored targets are always in range; the upper-bit check only guards the lookup.
   assign hit = rd_entry.valid
              && (rd_entry.tag == if_tag)
              && ((rd_entry.target >> PC_W) == '0);

   always_comb begin
      pred_taken  = 1'b0;
      pred_target = if_pc + PC_W'(4);
      if (!reset && hit) begin
         pred_taken  = rd_entry.uncond | bht_q[if_idx][1];
         pred_target = rd_entry.target[PC_W-1:0];
      end
   end

   assign pc_four = 32'(ex_pc) + 32'd4;
   assign pc_imm  = 32'(ex_pc) + ex_imm;

   assign act_taken  = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]);
   assign act_target = ex_jalr ? {ex_alu_result[31:1], 1'b0} : pc_imm;
   assign tgt_oob    = (act_target >> PC_W) != '0;

   // A taken target outside the PC space can never match the piped prediction.
   assign redirect = ex_valid & ~reset
                   & ((act_taken != ex_pred_taken)
                      | (act_taken & ((act_target[PC_W-1:0] != ex_pred_target) | tgt_oob)));

   assign redirect_pc = act_taken ? act_target : pc_four;

   assign ex_ctl    = ex_valid & (ex_branch | ex_jal | ex_jalr);
   assign btb_wr_en = ex_ctl & act_taken & ~reset;

   always_comb begin
      wr_entry        = '0;
      wr_entry.valid  = 1'b1;
      wr_entry.uncond = ex_jal | ex_jalr;
      wr_entry.tag    = ex_tag;
      wr_entry.target = 32'(act_target[PC_W-1:0]);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (redirect && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            bht_q[i] <= WNT;
         end
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (ex_valid && ex_branch) begin
            bht_q[ex_idx] <= sat_update(bht_q[ex_idx], act_taken);
         end
      end
   end

   assign mispredict_cnt = cnt_q;

endmodule
